// File: rtl/ciclo_lavagem_if.sv
// Bundle between the laundry front-end and the wash-cycle sequencer.
// The front-end (master) drives the start request; the sequencer (slave) reports status.
interface ciclo_lavagem_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          libera;
  logic          maq;
  logic [1:0]    tipo;
  logic          mostra;
  logic [1:0]    ocupada;
  logic [2:0]    fase0;
  logic [2:0]    fase1;
  logic [CW-1:0] restante;
  logic [1:0]    fim;
  logic          erro;

  modport master (
    output tick, libera, maq, tipo, mostra,
    input  ocupada, fase0, fase1, restante, fim, erro
  );

  modport slave (
    input  tick, libera, maq, tipo, mostra,
    output ocupada, fase0, fase1, restante, fim, erro
  );
endinterface

// File: rtl/ciclo_lavagem.sv
// Two independent wash-program sequencers (fill, wash, rinse, spin) started
// by the rising edge of libera; reports busy flags, phases and remaining time.
module ciclo_lavagem #(
  parameter int CW         = 8,
  parameter int T_ENCHER   = 3,
  parameter int T_LAVAR_R  = 5,
  parameter int T_LAVAR_N  = 10,
  parameter int T_LAVAR_P  = 20,
  parameter int T_ENXAGUAR = 4,
  parameter int T_CENTRIF  = 6
) (
  input  logic            clk,
  input  logic            reset,
  ciclo_lavagem_if.slave  bus
);

  typedef enum logic [2:0] {
    LIVRE    = 3'd0,
    ENCHER   = 3'd1,
    LAVAR    = 3'd2,
    ENXAGUAR = 3'd3,
    CENTRIF  = 3'd4,
    FIM      = 3'd5
  } fase_t;

  localparam logic [CW-1:0] D_ENC = CW'(T_ENCHER);
  localparam logic [CW-1:0] D_LVR = CW'(T_LAVAR_R);
  localparam logic [CW-1:0] D_LVN = CW'(T_LAVAR_N);
  localparam logic [CW-1:0] D_LVP = CW'(T_LAVAR_P);
  localparam logic [CW-1:0] D_ENX = CW'(T_ENXAGUAR);
  localparam logic [CW-1:0] D_CEN = CW'(T_CENTRIF);
  localparam logic [CW-1:0] UM    = CW'(1);

  fase_t         state_q [2];
  fase_t         state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [CW-1:0] lav_q   [2];
  logic [CW-1:0] lav_d   [2];
  logic [CW-1:0] rest_w  [2];

  logic          libera_q;
  logic          armado_q;
  logic          erro_q;
  logic          erro_d;
  logic          pedido;
  logic          aceita;
  logic [CW-1:0] lav_sel;

  // armado_q blocks a request in the first cycle after reset, so a libera
  // that is already high when reset is released does not start anything.
  assign pedido = bus.libera & ~libera_q & armado_q;
  assign aceita = pedido && (bus.tipo != 2'b11) && (state_q[bus.maq] == LIVRE);
  assign erro_d = pedido & ~aceita;

  always_comb begin
    lav_sel = D_LVR;
    case (bus.tipo)
      2'b01:   lav_sel = D_LVN;
      2'b10:   lav_sel = D_LVP;
      default: lav_sel = D_LVR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      libera_q <= 1'b0;
      armado_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      libera_q <= bus.libera;
      armado_q <= 1'b1;
      erro_q   <= erro_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_maq
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q[gi] <= LIVRE;
          cnt_q[gi]   <= '0;
          lav_q[gi]   <= '0;
        end else begin
          state_q[gi] <= state_d[gi];
          cnt_q[gi]   <= cnt_d[gi];
          lav_q[gi]   <= lav_d[gi];
        end
      end

      always_comb begin
        state_d[gi] = state_q[gi];
        cnt_d[gi]   = cnt_q[gi];
        lav_d[gi]   = lav_q[gi];
        case (state_q[gi])
          LIVRE: begin
            if (aceita && (bus.maq == 1'(gi))) begin
              state_d[gi] = ENCHER;
              cnt_d[gi]   = D_ENC;
              lav_d[gi]   = lav_sel;
            end
          end
          ENCHER, LAVAR, ENXAGUAR, CENTRIF: begin
            if (bus.tick) begin
              if (cnt_q[gi] == UM) begin
                case (state_q[gi])
                  ENCHER:   begin state_d[gi] = LAVAR;    cnt_d[gi] = lav_q[gi]; end
                  LAVAR:    begin state_d[gi] = ENXAGUAR; cnt_d[gi] = D_ENX;     end
                  ENXAGUAR: begin state_d[gi] = CENTRIF;  cnt_d[gi] = D_CEN;     end
                  default:  begin state_d[gi] = FIM;      cnt_d[gi] = '0;        end
                endcase
              end else begin
                cnt_d[gi] = cnt_q[gi] - UM;
              end
            end
          end
          default: begin
            state_d[gi] = LIVRE;
            cnt_d[gi]   = '0;
          end
        endcase
      end

      // Remaining time: current counter plus every phase still ahead.
      always_comb begin
        rest_w[gi] = '0;
        case (state_q[gi])
          ENCHER:   rest_w[gi] = cnt_q[gi] + lav_q[gi] + D_ENX + D_CEN;
          LAVAR:    rest_w[gi] = cnt_q[gi] + D_ENX + D_CEN;
          ENXAGUAR: rest_w[gi] = cnt_q[gi] + D_CEN;
          CENTRIF:  rest_w[gi] = cnt_q[gi];
          default:  rest_w[gi] = '0;
        endcase
      end
    end
  endgenerate

  assign bus.ocupada  = {state_q[1] != LIVRE, state_q[0] != LIVRE};
  assign bus.fim      = {state_q[1] == FIM, state_q[0] == FIM};
  assign bus.fase0    = state_q[0];
  assign bus.fase1    = state_q[1];
  assign bus.erro     = erro_q;
  assign bus.restante = rest_w[bus.mostra];

endmodule

// File: tb/tb_ciclo_lavagem.sv
// Bench for ciclo_lavagem: vector table, directed corner sequences and a
// randomized run against a tick-counting reference model.
module tb_ciclo_lavagem;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ciclo_lavagem_if #(.CW(CW)) bus ();
  ciclo_lavagem #(.CW(CW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: a machine is a program length plus count of ticks consumed.
  bit m_act [2];
  int m_el  [2];
  int m_len [2];
  bit m_erro, m_prev, m_primed;

  function automatic int wash_len(input logic [1:0] t);
    case (t)
      2'b01:   return 10;
      2'b10:   return 20;
      default: return 5;
    endcase
  endfunction

  function automatic int total(input int i);
    return 3 + m_len[i] + 4 + 6;
  endfunction

  function automatic int m_fase(input int i);
    if (!m_act[i]) return 0;
    if (m_el[i] == total(i)) return 5;
    if (m_el[i] < 3) return 1;
    if (m_el[i] < 3 + m_len[i]) return 2;
    if (m_el[i] < 3 + m_len[i] + 4) return 3;
    return 4;
  endfunction

  function automatic int m_rest(input int i);
    return m_act[i] ? total(i) - m_el[i] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_el[i] = 0; m_len[i] = 0;
    end
    m_erro = 0; m_prev = 0; m_primed = 0;
  endtask

  task automatic model_step();
    bit req;
    bit busy_old [2];
    req = m_primed && bus.libera && !m_prev;
    for (int i = 0; i < 2; i++) busy_old[i] = m_act[i];
    for (int i = 0; i < 2; i++) begin
      if (m_act[i]) begin
        if (m_el[i] == total(i)) begin
          m_act[i] = 0; m_el[i] = 0;
        end else if (bus.tick) begin
          m_el[i]++;
        end
      end
    end
    m_erro = 0;
    if (req) begin
      if (bus.tipo != 2'b11 && !busy_old[bus.maq]) begin
        m_act[bus.maq] = 1; m_el[bus.maq] = 0; m_len[bus.maq] = wash_len(bus.tipo);
      end else begin
        m_erro = 1;
      end
    end
    m_prev = bus.libera;
    m_primed = 1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fase0"}, bus.fase0, m_fase(0));
    chk({tag, ".fase1"}, bus.fase1, m_fase(1));
    chk({tag, ".ocupada"}, bus.ocupada, {30'd0, m_act[1], m_act[0]});
    chk({tag, ".fim"}, bus.fim, {30'd0, m_act[1] && m_el[1] == total(1), m_act[0] && m_el[0] == total(0)});
    chk({tag, ".erro"}, bus.erro, m_erro);
    chk({tag, ".restante"}, bus.restante, m_rest(bus.mostra));
  endtask

  task automatic set_in(input bit lib, input bit maq, input bit [1:0] tipo, input bit mostra, input bit tick);
    bus.libera = lib; bus.maq = maq; bus.tipo = tipo; bus.mostra = mostra; bus.tick = tick;
  endtask

  task automatic start(input bit maq, input bit [1:0] tipo, input bit mostra);
    set_in(0, maq, tipo, mostra, 0); cycle(); check_model("pre_start");
    set_in(1, maq, tipo, mostra, 0); cycle(); check_model("start");
    $display("start maq=%0d tipo=%0d restante=%0d", maq, tipo, bus.restante);
    bus.libera = 0;
  endtask

  typedef struct {
    bit lib; bit maq; bit [1:0] tipo; bit mostra; bit tick;
    bit [2:0] f0; bit [2:0] f1; bit [1:0] oc; bit [1:0] fim; bit er; int rest;
  } vec_t;
  vec_t vt [15];

  initial begin
    int cnt_fim, at1, at0, n_er;
    vt[0]  = '{0,0,2'd0,0,0, 3'd0,3'd0,2'b00,2'b00,0, 0};
    vt[1]  = '{1,0,2'd0,0,0, 3'd1,3'd0,2'b01,2'b00,0,18};
    vt[2]  = '{1,0,2'd0,0,1, 3'd1,3'd0,2'b01,2'b00,0,17};
    vt[3]  = '{1,0,2'd0,0,1, 3'd1,3'd0,2'b01,2'b00,0,16};
    vt[4]  = '{1,0,2'd0,0,1, 3'd2,3'd0,2'b01,2'b00,0,15};
    vt[5]  = '{1,0,2'd0,0,0, 3'd2,3'd0,2'b01,2'b00,0,15};
    vt[6]  = '{0,0,2'd0,0,1, 3'd2,3'd0,2'b01,2'b00,0,14};
    vt[7]  = '{1,0,2'd1,0,0, 3'd2,3'd0,2'b01,2'b00,1,14};
    vt[8]  = '{1,0,2'd1,0,0, 3'd2,3'd0,2'b01,2'b00,0,14};
    vt[9]  = '{0,1,2'd3,0,0, 3'd2,3'd0,2'b01,2'b00,0,14};
    vt[10] = '{1,1,2'd3,0,0, 3'd2,3'd0,2'b01,2'b00,1,14};
    vt[11] = '{0,1,2'd3,1,0, 3'd2,3'd0,2'b01,2'b00,0, 0};
    vt[12] = '{1,1,2'd2,1,0, 3'd2,3'd1,2'b11,2'b00,0,33};
    vt[13] = '{1,1,2'd2,1,1, 3'd2,3'd1,2'b11,2'b00,0,32};
    vt[14] = '{1,1,2'd2,0,1, 3'd2,3'd1,2'b11,2'b00,0,12};

    // Reset held while inputs toggle
    set_in(0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(i[0], i[1], 2'(i), i[0], 1);
      @(posedge clk); #1;
      chk("rst.ocupada", bus.ocupada, 0);
      chk("rst.fase0", bus.fase0, 0);
      chk("rst.fase1", bus.fase1, 0);
      chk("rst.fim", bus.fim, 0);
      chk("rst.erro", bus.erro, 0);
      chk("rst.restante", bus.restante, 0);
      $display("reset cycle %0d", i);
    end
    // libera already high at reset release must not start anything
    set_in(1, 0, 0, 0, 0);
    rst_n = 1;
    model_reset();
    cycle();
    check_model("release");
    chk("release.ocupada", bus.ocupada, 0);

    for (int v = 0; v < 15; v++) begin
      set_in(vt[v].lib, vt[v].maq, vt[v].tipo, vt[v].mostra, vt[v].tick);
      cycle();
      chk($sformatf("vec%0d.fase0", v), bus.fase0, vt[v].f0);
      chk($sformatf("vec%0d.fase1", v), bus.fase1, vt[v].f1);
      chk($sformatf("vec%0d.ocupada", v), bus.ocupada, vt[v].oc);
      chk($sformatf("vec%0d.fim", v), bus.fim, vt[v].fim);
      chk($sformatf("vec%0d.erro", v), bus.erro, vt[v].er);
      chk($sformatf("vec%0d.restante", v), bus.restante, vt[v].rest);
      $display("vec %0d: fase0=%0d fase1=%0d restante=%0d", v, bus.fase0, bus.fase1, bus.restante);
    end
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin cycle(); check_model("drain"); end

    // Full quick program on machine 0
    start(0, 2'b00, 0);
    chk("quick.restante", bus.restante, 18);
    cnt_fim = 0;
    bus.tick = 1;
    for (int k = 1; k <= 20; k++) begin
      cycle(); check_model("quick");
      if (bus.fim[0]) begin cnt_fim++; chk("quick.fim_at", k, 18); end
    end
    chk("quick.fim_cycles", cnt_fim, 1);
    chk("quick.end_fase0", bus.fase0, 0);

    // Concurrent programs: heavy on 0, normal on 1 after 5 ticks
    start(0, 2'b10, 0);
    chk("conc.rest0", bus.restante, 33);
    bus.tick = 1;
    for (int k = 0; k < 5; k++) begin cycle(); check_model("conc.pre"); end
    start(1, 2'b01, 1);
    chk("conc.rest1", bus.restante, 23);
    at1 = -1; at0 = -1;
    bus.tick = 1;
    for (int k = 1; k <= 30; k++) begin
      cycle(); check_model("conc");
      if (bus.fim[1]) at1 = k;
      if (bus.fim[0]) at0 = k;
    end
    chk("conc.fim1_at", at1, 23);
    chk("conc.fim0_at", at0, 28);
    $display("concurrent: fim1 at %0d, fim0 at %0d", at1, at0);

    // Busy rejection, then libera held high
    start(0, 2'b00, 0);
    bus.tick = 1; cycle(); check_model("busy.t"); cycle(); check_model("busy.t");
    set_in(0, 0, 2'b01, 0, 0); cycle(); check_model("busy.low");
    set_in(1, 0, 2'b01, 0, 0); cycle(); check_model("busy.req");
    chk("busy.erro", bus.erro, 1);
    chk("busy.restante", bus.restante, 16);
    n_er = 0;
    for (int k = 0; k < 50; k++) begin
      bus.tick = 1'($urandom_range(0, 1));
      cycle(); check_model("hold");
      if (bus.erro) n_er++;
    end
    chk("hold.erro_count", n_er, 0);
    bus.tick = 1;
    for (int k = 0; k < 25; k++) begin cycle(); check_model("hold.drain"); end
    chk("hold.fase0", bus.fase0, 0);
    $display("hold: erro pulses=%0d", n_er);

    // Invalid program
    set_in(0, 1, 2'b11, 1, 0); cycle(); check_model("inv.low");
    set_in(1, 1, 2'b11, 1, 0); cycle(); check_model("inv.req");
    chk("inv.erro", bus.erro, 1);
    chk("inv.fase1", bus.fase1, 0);
    bus.libera = 0; cycle(); check_model("inv.after");
    chk("inv.erro_clear", bus.erro, 0);

    // Request landing in the FIM cycle
    start(0, 2'b00, 0);
    bus.tick = 1;
    for (int k = 0; k < 18; k++) begin cycle(); check_model("fimreq.run"); end
    chk("fimreq.fase0", bus.fase0, 5);
    set_in(1, 0, 2'b00, 0, 0); cycle(); check_model("fimreq");
    chk("fimreq.erro", bus.erro, 1);
    chk("fimreq.livre", bus.fase0, 0);
    $display("request in FIM: erro=%0d fase0=%0d", bus.erro, bus.fase0);

    // Asynchronous reset in the middle of the wash phase
    start(0, 2'b00, 0);
    bus.tick = 1;
    for (int k = 0; k < 6; k++) begin cycle(); check_model("ar.run"); end
    chk("ar.restante", bus.restante, 12);
    chk("ar.fase0", bus.fase0, 2);
    #3 rst_n = 0;
    #1;
    chk("ar.async_fase0", bus.fase0, 0);
    chk("ar.async_ocupada", bus.ocupada, 0);
    chk("ar.async_restante", bus.restante, 0);
    @(posedge clk); #1;
    set_in(1, 0, 2'b00, 0, 1);
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(); check_model("ar.after");
      chk("ar.after_fase0", bus.fase0, 0);
    end
    $display("async reset: fase0=%0d", bus.fase0);

    // Randomized run
    set_in(0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) bus.libera = ~bus.libera;
      bus.maq    = 1'($urandom_range(0, 1));
      bus.tipo   = 2'($urandom_range(0, 3));
      bus.mostra = 1'($urandom_range(0, 1));
      bus.tick   = 1'($urandom_range(0, 1));
      cycle();
      check_model("rand");
      if (bus.erro || bus.fim != 0)
        $display("rand %0d: ocupada=%b fim=%b erro=%0d", k, bus.ocupada, bus.fim, bus.erro);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ciclo_lavagem.md
Name: ciclo_lavagem

Overview:
- Wash-cycle sequencer that sits directly downstream of the laundry front-end (machine selection, bill counting, wash-type selection, machine release).
- On each rising edge of the release signal it starts a timed wash program on the selected machine: fill, wash, rinse, spin.
- Runs the two machines independently.
- Reports per-machine busy status back to the selection logic and provides the remaining time for the 7-segment display path.

Parameters:
- CW, 8, width of phase counters and of restante
- T_ENCHER, 3, fill phase duration in ticks
- T_LAVAR_R, 5, wash duration in ticks, quick program (tipo 00)
- T_LAVAR_N, 10, wash duration in ticks, normal program (tipo 01)
- T_LAVAR_P, 20, wash duration in ticks, heavy program (tipo 10)
- T_ENXAGUAR, 4, rinse duration in ticks
- T_CENTRIF, 6, spin duration in ticks

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle time-base enable from the frequency divider; 1 tick = 1 time unit
- libera  input  1  release level from the front-end; a start is requested only on its 0->1 edge
- maq  input  1  target machine index (0 or 1), sampled on the libera edge cycle
- tipo  input  2  wash program, sampled on the libera edge cycle: 00 quick, 01 normal, 10 heavy, 11 invalid
- mostra  input  1  machine index whose remaining time drives restante
- ocupada  output  2  per-machine busy flag, bit i = machine i
- fase0  output  3  state code of machine 0
- fase1  output  3  state code of machine 1
- restante  output  CW  total remaining ticks of machine `mostra`
- fim  output  2  one-cycle completion pulse per machine
- erro  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - Both machines go to LIVRE; counters are 0; the libera edge register is 0.
  - ocupada=00, fim=00, erro=0, fase0=fase1=000, restante=0.
- Edge detection:
  - A registered copy of libera is kept.
  - A request exists in cycle N iff libera=1 in N and libera=0 in N-1.
  - Holding libera high never retriggers.
  - libera already high when reset is released does not produce a request.
- Per-machine states and codes: LIVRE 000, ENCHER 001, LAVAR 010, ENXAGUAR 011, CENTRIF 100, FIM 101.
- Acceptance:
  - A request in cycle N is accepted iff machine `maq` is in LIVRE and tipo != 11.
  - The accepted machine enters ENCHER at N+1 with counter=T_ENCHER, and the wash duration selected by tipo is latched.
  - A request is rejected if tipo=11 or the target machine is in any state other than LIVRE (FIM included). On rejection: erro=1 in cycle N+1 only, and neither machine changes state.
- Phase timing:
  - On entry to a phase the counter is loaded with that phase's duration.
  - Each cycle with tick=1 decrements the counter.
  - A tick arriving while counter=1 moves to the next phase and loads its duration: ENCHER->LAVAR (latched wash duration) -> ENXAGUAR -> CENTRIF -> FIM.
  - A tick in the acceptance cycle N is ignored.
  - A tick in the first cycle of a phase counts.
  - With tick=0 the state and counter hold.
- FIM:
  - Lasts exactly one clock cycle, then the machine returns to LIVRE regardless of tick.
  - fim[i]=1 during FIM.
- ocupada[i]=1 in ENCHER, LAVAR, ENXAGUAR, CENTRIF and FIM; it is 0 only in LIVRE.
- Independence: both machines may run concurrently, and one tick decrements both machines' counters in the same cycle.
- restante:
  - Combinational from registered state: current counter plus the full durations of all remaining phases of machine `mostra`.
  - It is 0 in LIVRE and FIM.
  - Example, quick program in the first ENCHER cycle: 3+5+4+6=18.
  - Width CW; the default durations cannot overflow (maximum 33).
- Durations of 0 are illegal parameter values and are not supported.
- Outputs are registered except restante. fase0 and fase1 are the state registers.

Test Plan:
1. Hold reset=0 while toggling libera, tick and maq -> ocupada=00, fim=00, erro=0, fase0=fase1=000, restante=0 throughout.
2. Release reset; drive libera 0->1 with maq=0, tipo=00, mostra=0 -> next cycle fase0=001, ocupada=01, restante=18. Then apply 18 ticks -> fase0 steps 001->010 after 3 ticks, ->011 after 5 more, ->100 after 4 more, ->101 after 6 more. fim=01 for exactly one cycle, then fase0=000 and ocupada=00.
3. Start machine 0 with tipo=10 (restante=33). After 5 ticks start machine 1 with tipo=01. Set mostra=1 -> restante=23 and both counters decrement on shared ticks. Machine 1 asserts fim after 23 further ticks; machine 0 asserts fim after 28 further ticks.
4. While machine 0 is busy, request machine 0 again -> erro=1 for one cycle and machine 0's state and counter are unchanged. Then hold libera=1 for 50 cycles -> no further erro and no new start.
5. Request with tipo=11 and machine 1 idle -> erro pulses once and fase1 stays 000. Separately, request machine 0 in the cycle it is in FIM -> rejected with erro=1, and machine 0 goes to LIVRE normally.
6. Assert reset mid-LAVAR with restante=12 -> in the same cycle, asynchronously, fase0=000, ocupada=00, restante=0. Deassert reset -> machine stays LIVRE until a new libera edge.
